// File: rtl/snake_rand_gen.sv
// Apple/barrier cell generator for the snake game: two free-running LFSRs feed a
// search FSM that publishes a non-conflicting {apple, barrier} pair on request.
module snake_rand_gen #(
  parameter logic [7:0] SEED_A = 8'hA5,
  parameter logic [7:0] SEED_B = 8'h3C
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        new_rnd,
  input  logic [71:0] snake,
  output logic [7:0]  random_num,
  output logic [7:0]  random_num_2,
  output logic        valid
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [7:0] SEED_A_EFF = (SEED_A == 8'h00) ? 8'h01 : SEED_A;
  localparam logic [7:0] SEED_B_EFF = (SEED_B == 8'h00) ? 8'h01 : SEED_B;

  typedef enum logic [1:0] {SEARCH_A, SEARCH_B, HOLD} state_e;

  function automatic logic [7:0] lfsr_step(input logic [7:0] q);
    return (q == 8'h00) ? 8'h01 : {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  function automatic logic [7:0] cell_map(input logic [5:0] v);
    return 8'd10 * ({5'd0, v[5:3]} + 8'd1) + {5'd0, v[2:0]} + 8'd2;
  endfunction

  function automatic logic is_occupied(input logic [7:0] c, input logic [71:0] s);
    logic hit;
    hit = (c == s[71:64]);
    for (int i = 0; i < 8; i++) begin
      if (s[i*8 +: 8] != 8'h00 && s[i*8 +: 8] == c) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic near_head(input logic [7:0] c, input logic [7:0] h);
    return (c == h + 8'd1) || (c == h - 8'd1) || (c == h + 8'd10) || (c == h - 8'd10);
  endfunction

  state_e      state_q, state_d;
  logic [7:0]  lfsr_a_q, lfsr_a_d, lfsr_b_q, lfsr_b_d;
  logic [5:0]  attempt_q, attempt_d, scan_q, scan_d;
  logic [7:0]  cand_a_q, cand_a_d, cand_b_q, cand_b_d;
  logic [7:0]  rnd_a_q, rnd_a_d, rnd_b_q, rnd_b_d;
  logic        valid_q, valid_d;

  logic        scan_mode;
  logic [7:0]  try_a, try_b, head;
  logic        rej_a, rej_b, conflict;

  assign head      = snake[71:64];
  assign scan_mode = (attempt_q == 6'd63);
  assign try_a     = cell_map(scan_mode ? scan_q : lfsr_a_q[5:0]);
  assign try_b     = cell_map(scan_mode ? scan_q : lfsr_b_q[5:0]);
  assign rej_a     = is_occupied(try_a, snake);
  assign rej_b     = is_occupied(try_b, snake) || (try_b == cand_a_q) || near_head(try_b, head);
  assign conflict  = is_occupied(cand_a_q, snake) || is_occupied(cand_b_q, snake)
                   || near_head(cand_b_q, head);

  always_comb begin
    state_d   = state_q;
    lfsr_a_d  = lfsr_step(lfsr_a_q);
    lfsr_b_d  = lfsr_step(lfsr_b_q);
    attempt_d = attempt_q;
    scan_d    = scan_q;
    cand_a_d  = cand_a_q;
    cand_b_d  = cand_b_q;
    rnd_a_d   = rnd_a_q;
    rnd_b_d   = rnd_b_q;
    valid_d   = 1'b0;
    case (state_q)
      SEARCH_A, SEARCH_B: begin
        if ((state_q == SEARCH_A) ? rej_a : rej_b) begin
          // Attempt counter saturates so the scan source stays selected until acceptance.
          if (scan_mode) scan_d = scan_q + 6'd1;
          else           attempt_d = attempt_q + 6'd1;
        end else begin
          attempt_d = 6'd0;
          scan_d    = 6'd0;
          if (state_q == SEARCH_A) begin
            cand_a_d = try_a;
            state_d  = SEARCH_B;
          end else begin
            cand_b_d = try_b;
            state_d  = HOLD;
          end
        end
      end
      HOLD: begin
        if (conflict) begin
          state_d = SEARCH_A;
        end else if (new_rnd) begin
          rnd_a_d = cand_a_q;
          rnd_b_d = cand_b_q;
          valid_d = 1'b1;
          state_d = SEARCH_A;
        end
      end
      default: state_d = SEARCH_A;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SEARCH_A;
      lfsr_a_q  <= SEED_A_EFF;
      lfsr_b_q  <= SEED_B_EFF;
      attempt_q <= 6'd0;
      scan_q    <= 6'd0;
      cand_a_q  <= 8'd0;
      cand_b_q  <= 8'd0;
      rnd_a_q   <= 8'd45;
      rnd_b_q   <= 8'd67;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_a_q  <= lfsr_a_d;
      lfsr_b_q  <= lfsr_b_d;
      attempt_q <= attempt_d;
      scan_q    <= scan_d;
      cand_a_q  <= cand_a_d;
      cand_b_q  <= cand_b_d;
      rnd_a_q   <= rnd_a_d;
      rnd_b_q   <= rnd_b_d;
      valid_q   <= valid_d;
    end
  end

  assign random_num   = rnd_a_q;
  assign random_num_2 = rnd_b_q;
  assign valid        = valid_q;

endmodule

// File: doc/snake_rand_gen.md
SNAKE_RAND_GEN -- requirements
Module: snake_rand_gen

Interface
REQ-001 SHALL have parameter SEED_A, default 8'hA5, reset seed of LFSR A; a value of 0 SHALL be replaced by 8'h01.
REQ-002 SHALL have parameter SEED_B, default 8'h3C, reset seed of LFSR B; a value of 0 SHALL be replaced by 8'h01.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port new_rnd, input, 1; 1 means the game core is idle and a new pair may be published, 0 means hold the outputs.
REQ-006 SHALL have port snake, input, 72, nine 8-bit cell indices; [71:64] is the head, and a body segment of 0 is unused.
REQ-007 SHALL have port random_num, output, 8, next apple cell.
REQ-008 SHALL have port random_num_2, output, 8, next barrier cell.
REQ-009 SHALL have port valid, output, 1, one-cycle pulse when a new pair is published.

Function
REQ-010 SHALL keep two 8-bit Fibonacci LFSRs that step every clock in every state: q <= {q[6:0], q[7]^q[5]^q[4]^q[3]}.
REQ-011 SHALL reload an LFSR that reaches 8'h00 with 8'h01 on the next edge.
REQ-012 SHALL map a 6-bit source v to a cell index as 10*(v[5:3]+1) + v[2:0] + 2, using 8-bit unsigned arithmetic; every result lies in the legal range 12..89 with column 2..9.
REQ-013 SHALL use an FSM with states SEARCH_A, SEARCH_B and HOLD; reset state is SEARCH_A.
REQ-014 In SEARCH_A, the candidate SHALL be map(lfsr_a[5:0]).
REQ-015 The SEARCH_A candidate SHALL be rejected if it equals the head or any nonzero body segment.
REQ-016 On acceptance in SEARCH_A: latch the candidate into cand_a, clear the attempt counter, and go to SEARCH_B.
REQ-017 In SEARCH_B, the candidate SHALL be map(lfsr_b[5:0]).
REQ-018 The SEARCH_B candidate SHALL be rejected if it equals any occupied snake cell, or equals cand_a, or equals head+1, head-1, head+10 or head-10.
REQ-019 On acceptance in SEARCH_B: latch the candidate into cand_b, clear the attempt counter, and go to HOLD.
REQ-020 Each rejection SHALL increment a 6-bit attempt counter.
REQ-021 After 63 consecutive rejections in one SEARCH state, the source SHALL switch to a 6-bit scan counter: it starts at 0, increments by 1 per cycle, and wraps 63->0.
REQ-022 The scan source SHALL be used until acceptance; acceptance is guaranteed because at most 15 cells are excluded.
REQ-023 In HOLD, cand_a and cand_b SHALL be re-checked every cycle against the current snake and head.
REQ-024 If either candidate conflicts in HOLD, the FSM SHALL go to SEARCH_A without publishing; conflict takes priority over new_rnd.
REQ-025 In HOLD with no conflict and new_rnd=1: random_num<=cand_a, random_num_2<=cand_b, valid<=1 for exactly one cycle, next state SEARCH_A.
REQ-026 In HOLD with new_rnd=0, the FSM SHALL stay in HOLD and outputs SHALL be unchanged.
REQ-027 random_num and random_num_2 SHALL change only on a publish edge and SHALL never hold an illegal cell.
REQ-028 Minimum latency from SEARCH_A entry to valid SHALL be 3 edges.

Reset
REQ-029 While rst=1: state=SEARCH_A, lfsr_a=SEED_A, lfsr_b=SEED_B, attempt and scan counters=0, cand_a=cand_b=0.
REQ-030 While rst=1: random_num=8'd45, random_num_2=8'd67, valid=0.
REQ-031 Assertion of rst mid-search or during HOLD SHALL discard candidates immediately, with no publish.

Verification
REQ-032 Defaults, rst released, snake={12, zeros}, new_rnd=1 -> edge1 cand_a=57; edge2 cand_b=83 (lfsr_b=8'h79); edge3 random_num=57, random_num_2=83, valid=1 for one cycle.
REQ-033 Same as REQ-032 with new_rnd=0 for 10 cycles -> outputs stay 45/67, valid=0; new_rnd raised -> publish 57/83 on the next edge.
REQ-034 In HOLD, snake head changed to 57 -> return to SEARCH_A; published apple never 57 while the head is 57.
REQ-035 Snake occupying 9 cells including 57, head 56 -> the barrier is never 55, 57, 46 or 66, and the apple is never a snake cell, over 1000 publishes.
REQ-036 Forced LFSR 8'h00 -> 8'h01 on the next edge; forced 63 rejections -> scan path accepts within 64 further cycles.
REQ-037 rst pulsed during SEARCH_B -> outputs 45/67, valid=0, lfsr_a=SEED_A on the following cycle.
